// File: rtl/module4_cfo_cmul_sched.sv
// Fine-CFO phasor rotation: four real products sequenced through one shared external multiplier.
// Build option MODULE4_CFO_CMUL_SAT_EN: saturate the rounded result instead of wrapping it.
//
// state | meaning
// IDLE  | waiting for a sample, s_ready high
// P0    | re*cos  -> acc_re
// P1    | im*sin  subtracted from acc_re
// P2    | re*sin  -> acc_im
// P3    | im*cos  added to acc_im, result narrowed and registered
// OUT   | result held on m_*, waiting for m_ready
module module4_cfo_cmul_sched #(
  parameter int DATA_W = 16,
  parameter int FRAC   = 15,
  parameter int CNT_W  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_re,
  input  logic [DATA_W-1:0]     s_im,
  input  logic [DATA_W-1:0]     s_cos,
  input  logic [DATA_W-1:0]     s_sin,
  input  logic                  s_last,
  output logic [DATA_W-1:0]     mul_din0,
  output logic [DATA_W-1:0]     mul_din1,
  input  logic [2*DATA_W-1:0]   mul_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_re,
  output logic [DATA_W-1:0]     m_im,
  output logic                  m_last,
  output logic [CNT_W-1:0]      smp_cnt
);

  localparam int ACC_W = 2*DATA_W + 1;
  localparam logic signed [ACC_W-1:0] RND_ADD = ACC_W'(1 << (FRAC-1));

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, OUT} state_t;

  state_t                   state;
  logic [DATA_W-1:0]        re_q, im_q, cos_q, sin_q;
  logic                     last_q;
  logic signed [ACC_W-1:0]  acc_re, acc_im;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  acc_im_sum;
  logic                     accept;

  // Round half up, then arithmetic shift; the shifted value fits in ACC_W-FRAC bits.
  function automatic logic [DATA_W-1:0] narrow(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
`ifdef MODULE4_CFO_CMUL_SAT_EN
    logic signed [ACC_W-1:0] sat_hi;
    logic signed [ACC_W-1:0] sat_lo;
    sat_hi = ACC_W'((1 << (DATA_W-1)) - 1);
    sat_lo = -sat_hi - ACC_W'(1);
    sh = (a + RND_ADD) >>> FRAC;
    if (sh > sat_hi)
      narrow = DATA_W'(sat_hi);
    else if (sh < sat_lo)
      narrow = DATA_W'(sat_lo);
    else
      narrow = DATA_W'(sh);
`else
    sh = (a + RND_ADD) >>> FRAC;
    narrow = DATA_W'(sh);
`endif
  endfunction

  assign prod       = ACC_W'($signed(mul_dout));
  assign acc_im_sum = acc_im + prod;
  assign s_ready    = (state == IDLE) || ((state == OUT) && m_ready);
  assign accept     = s_valid && s_ready;

  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    case (state)
      P0: begin mul_din0 = re_q; mul_din1 = cos_q; end
      P1: begin mul_din0 = im_q; mul_din1 = sin_q; end
      P2: begin mul_din0 = re_q; mul_din1 = sin_q; end
      P3: begin mul_din0 = im_q; mul_din1 = cos_q; end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state   <= IDLE;
      re_q    <= '0;
      im_q    <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      last_q  <= 1'b0;
      acc_re  <= '0;
      acc_im  <= '0;
      m_valid <= 1'b0;
      m_re    <= '0;
      m_im    <= '0;
      m_last  <= 1'b0;
      smp_cnt <= '0;
    end else begin
      if (accept) begin
        re_q   <= s_re;
        im_q   <= s_im;
        cos_q  <= s_cos;
        sin_q  <= s_sin;
        last_q <= s_last;
      end
      case (state)
        IDLE: if (s_valid) state <= P0;
        P0: begin
          acc_re <= prod;
          state  <= P1;
        end
        P1: begin
          acc_re <= acc_re - prod;
          state  <= P2;
        end
        P2: begin
          acc_im <= prod;
          state  <= P3;
        end
        P3: begin
          acc_im  <= acc_im_sum;
          m_re    <= narrow(acc_re);
          m_im    <= narrow(acc_im_sum);
          m_last  <= last_q;
          m_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            smp_cnt <= smp_cnt + CNT_W'(1);
            state   <= s_valid ? P0 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_module4_cfo_cmul_sched.sv
// Directed bench for module4_cfo_cmul_sched; models the shared multiplier and checks results, timing and handshakes.
module tb_module4_cfo_cmul_sched;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        s_valid, s_ready, s_last;
  logic [15:0] s_re, s_im, s_cos, s_sin;
  logic [15:0] mul_din0, mul_din1;
  logic [31:0] mul_dout;
  logic        m_valid, m_ready, m_last;
  logic [15:0] m_re, m_im;
  logic [15:0] smp_cnt;

  int vecs = 0;
  int errs = 0;

  int st_re [8];
  int st_im [8];
  int st_cos[8];
  int st_sin[8];

  logic [15:0] held_re, held_im;

  always #5 ap_clk = ~ap_clk;

  assign mul_dout = 32'($signed(mul_din0) * $signed(mul_din1));

  module4_cfo_cmul_sched dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_re     (s_re),
    .s_im     (s_im),
    .s_cos    (s_cos),
    .s_sin    (s_sin),
    .s_last   (s_last),
    .mul_din0 (mul_din0),
    .mul_din1 (mul_din1),
    .mul_dout (mul_dout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_re     (m_re),
    .m_im     (m_im),
    .m_last   (m_last),
    .smp_cnt  (smp_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int re, input int im, input int c, input int s, input logic last);
    s_re   = re[15:0];
    s_im   = im[15:0];
    s_cos  = c[15:0];
    s_sin  = s[15:0];
    s_last = last;
  endtask

  // Reference rotation with round-half-up, full-precision arithmetic.
  function automatic logic [15:0] rot(input int re, input int im, input int c, input int s, input bit imag);
    longint p;
    if (imag) p = longint'(re) * s + longint'(im) * c;
    else      p = longint'(re) * c - longint'(im) * s;
    p = (p + 64'sd16384) >>> 15;
`ifdef MODULE4_CFO_CMUL_SAT_EN
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
`endif
    return p[15:0];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      st_re[i]  = 1000*i - 3000;
      st_im[i]  = 500 - 700*i;
      st_cos[i] = 30000 - 1000*i;
      st_sin[i] = 1000*i - 12000;
    end
    ap_rst_n = 1'b0;
    s_valid  = 1'b0;
    m_ready  = 1'b0;
    drive(0, 0, 0, 0, 1'b0);
    #1;
    chk("rst_s_ready", 16'(s_ready), 16'd1);
    chk("rst_m_valid", 16'(m_valid), 16'd0);
    chk("rst_m_re", m_re, 16'd0);
    chk("rst_m_im", m_im, 16'd0);
    chk("rst_m_last", 16'(m_last), 16'd0);
    chk("rst_smp_cnt", smp_cnt, 16'd0);
    chk("rst_din0", mul_din0, 16'd0);
    chk("rst_din1", mul_din1, 16'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // identity and latency
    @(negedge ap_clk);
    drive(16384, 0, 32767, 0, 1'b0);
    s_valid = 1'b1;
    chk("id_s_ready", 16'(s_ready), 16'd1);
    @(posedge ap_clk); #1 s_valid = 1'b0;
    @(negedge ap_clk);
    chk("id_p0_din0", mul_din0, 16'd16384);
    chk("id_p0_din1", mul_din1, 16'h7fff);
    @(negedge ap_clk);
    chk("id_p1_s_ready", 16'(s_ready), 16'd0);
    repeat (2) @(negedge ap_clk);
    chk("id_p3_m_valid", 16'(m_valid), 16'd0);
    @(negedge ap_clk);
    chk("id_out_m_valid", 16'(m_valid), 16'd1);
    chk("id_m_re", m_re, 16'd16384);
    chk("id_m_im", m_im, 16'd0);
    chk("id_out_din0", mul_din0, 16'd0);
    chk("id_out_s_ready", 16'(s_ready), 16'd0);
    m_ready = 1'b1;
    #1 chk("id_out_s_ready_mr", 16'(s_ready), 16'd1);
    @(posedge ap_clk); #1 m_ready = 1'b0;
    @(negedge ap_clk);
    chk("id_idle_m_valid", 16'(m_valid), 16'd0);
    chk("id_smp_cnt", smp_cnt, 16'd1);

    // quarter rotation held under backpressure
    drive(1000, -2000, 0, 32767, 1'b1);
    s_valid = 1'b1;
    @(posedge ap_clk); #1 s_valid = 1'b0;
    repeat (5) @(negedge ap_clk);
    chk("qr_m_valid", 16'(m_valid), 16'd1);
    chk("qr_m_re", m_re, 16'd2000);
    chk("qr_m_im", m_im, 16'd1000);
    chk("qr_m_last", 16'(m_last), 16'd1);
    held_re = m_re;
    held_im = m_im;
    for (int k = 0; k < 10; k++) begin
      @(negedge ap_clk);
      chk("bp_m_re", m_re, 16'd2000);
      chk("bp_m_im", m_im, 16'd1000);
      chk("bp_m_last", 16'(m_last), 16'd1);
      chk("bp_m_valid", 16'(m_valid), 16'd1);
      chk("bp_s_ready", 16'(s_ready), 16'd0);
      chk("bp_din0", mul_din0, 16'd0);
      chk("bp_din1", mul_din1, 16'd0);
    end

    // release: handshake and saturation-case acceptance in the same cycle
    drive(-32768, -32768, -32768, 32767, 1'b0);
    s_valid = 1'b1;
    m_ready = 1'b1;
    #1 chk("rel_s_ready", 16'(s_ready), 16'd1);
    @(posedge ap_clk); #1 begin s_valid = 1'b0; m_ready = 1'b0; end
    @(negedge ap_clk);
    chk("rel_p0_din0", mul_din0, 16'h8000);
    chk("rel_m_valid", 16'(m_valid), 16'd0);
    chk("rel_smp_cnt", smp_cnt, 16'd2);
    repeat (4) @(negedge ap_clk);
    chk("sat_m_valid", 16'(m_valid), 16'd1);
`ifdef MODULE4_CFO_CMUL_SAT_EN
    chk("sat_m_re", m_re, 16'h7fff);
`else
    chk("sat_m_re", m_re, 16'hffff);
`endif
    chk("sat_m_im", m_im, 16'd1);
    chk("sat_m_last", 16'(m_last), 16'd0);

    // streaming: first sample accepted in the same cycle the saturation result drains
    drive(st_re[0], st_im[0], st_cos[0], st_sin[0], 1'b0);
    s_valid = 1'b1;
    m_ready = 1'b1;
    @(posedge ap_clk);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge ap_clk);
        chk("st_busy_m_valid", 16'(m_valid), 16'd0);
        chk("st_busy_s_ready", 16'(s_ready), 16'd0);
      end
      @(negedge ap_clk);
      chk("st_m_valid", 16'(m_valid), 16'd1);
      chk("st_s_ready", 16'(s_ready), 16'd1);
      chk("st_m_re", m_re, rot(st_re[i], st_im[i], st_cos[i], st_sin[i], 1'b0));
      chk("st_m_im", m_im, rot(st_re[i], st_im[i], st_cos[i], st_sin[i], 1'b1));
      chk("st_m_last", 16'(m_last), (i == 7) ? 16'd1 : 16'd0);
      if (i < 7) drive(st_re[i+1], st_im[i+1], st_cos[i+1], st_sin[i+1], (i + 1) == 7);
      else       s_valid = 1'b0;
      @(posedge ap_clk);
    end
    @(negedge ap_clk);
    m_ready = 1'b0;
    chk("st_idle_m_valid", 16'(m_valid), 16'd0);
    chk("st_smp_cnt", smp_cnt, 16'd11);
    chk("st_idle_s_ready", 16'(s_ready), 16'd1);

    // asynchronous reset during P2
    drive(5000, 7000, 20000, -15000, 1'b1);
    s_valid = 1'b1;
    @(posedge ap_clk); #1 s_valid = 1'b0;
    @(posedge ap_clk);
    @(posedge ap_clk);
    #1 chk("ar_p2_din1", mul_din1, 16'(-15000));
    #1 ap_rst_n = 1'b0;
    #1;
    chk("ar_m_re", m_re, 16'd0);
    chk("ar_m_im", m_im, 16'd0);
    chk("ar_m_last", 16'(m_last), 16'd0);
    chk("ar_smp_cnt", smp_cnt, 16'd0);
    chk("ar_s_ready", 16'(s_ready), 16'd1);
    chk("ar_din0", mul_din0, 16'd0);
    chk("ar_m_valid", 16'(m_valid), 16'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    drive(-12000, 3000, 15000, 25000, 1'b0);
    s_valid = 1'b1;
    @(posedge ap_clk); #1 s_valid = 1'b0;
    repeat (5) @(negedge ap_clk);
    chk("ar_new_m_valid", 16'(m_valid), 16'd1);
    chk("ar_new_m_re", m_re, rot(-12000, 3000, 15000, 25000, 1'b0));
    chk("ar_new_m_im", m_im, rot(-12000, 3000, 15000, 25000, 1'b1));
    chk("ar_new_m_last", 16'(m_last), 16'd0);
    m_ready = 1'b1;
    @(posedge ap_clk); #1 m_ready = 1'b0;
    @(negedge ap_clk);
    chk("ar_new_smp_cnt", smp_cnt, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
